// File: rtl/ifetch_prefetch.sv
// Sequential instruction prefetch buffer between the CPU fetch port and instruction RAM.
// Latency: buffer hit 1 cycle; miss/flush 3 cycles; each dropped memory response adds 2.
// Backpressure: issue stalls while buffered + in-flight words reach DEPTH; dropped responses replay.
//
// Ports:
//   i_clk, i_reset                  clock, asynchronous active-high reset
//   i_ins_rd_addr/_req              CPU fetch address (held until o_ins_rd_rdy) and request
//   o_ins_rd_data/_rdy              instruction word and registered one-cycle completion pulse
//   o_mem_rd_addr/_req              memory read address and issue strobe
//   i_mem_rd_data/_rdy              memory response, valid one cycle after issue
module ifetch_prefetch #(
  parameter int          DEPTH      = 4,
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_ins_rd_addr,
  input  logic        i_ins_rd_req,
  output logic [15:0] o_ins_rd_data,
  output logic        o_ins_rd_rdy,
  output logic [15:0] o_mem_rd_addr,
  output logic        o_mem_rd_req,
  input  logic [15:0] i_mem_rd_data,
  input  logic        i_mem_rd_rdy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_ONE   = 1;
  localparam logic [PW-1:0] P_ONE   = 1;
  localparam logic [CW:0]   C_DEPTH = (CW+1)'(DEPTH);

  logic [15:0]   r_buf [0:DEPTH-1];
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_ha;
  logic [15:0]   r_fa;
  logic          r_infl;
  logic [15:0]   r_ia;
  logic          r_discard;
  logic          r_busy;
  logic [15:0]   r_ba;
  logic          r_rdy;
  logic [15:0]   r_data;

  logic          w_empty;
  logic          w_resp_ok;
  logic          w_drop;
  logic          w_accept;
  logic          w_hit;
  logic          w_pend;
  logic          w_miss;
  logic          w_busy_head;
  logic          w_bypass;
  logic          w_pop;
  logic          w_push;
  logic          w_deliver;
  logic          w_issue;
  logic [CW:0]   w_occ;
  logic [PW-1:0] w_wr_ptr;
  logic [15:0]   w_head;
  logic [15:0]   w_out_data;

  assign w_empty   = (r_count == '0);
  assign w_head    = r_buf[r_rd_ptr];
  assign w_wr_ptr  = r_rd_ptr + r_count[PW-1:0];

  // A discarded request belongs to a stale address stream: its response is
  // neither stored nor allowed to trigger a replay.
  assign w_resp_ok = r_infl & i_mem_rd_rdy & ~r_discard;
  assign w_drop    = r_infl & ~i_mem_rd_rdy & ~r_discard;

  assign w_accept  = i_ins_rd_req & ~r_busy;
  assign w_hit     = w_accept & ~w_empty & (i_ins_rd_addr == r_ha);
  assign w_pend    = w_accept & w_empty & (i_ins_rd_addr == r_ha) &
                     r_infl & ~r_discard & (r_ia == r_ha);
  assign w_miss    = w_accept & ~w_hit & ~w_pend;

  // Busy completes from the head entry, or straight from the memory
  // response when the buffer is empty (saves a cycle on misses).
  assign w_busy_head = r_busy & ~w_empty & (r_ha == r_ba);
  assign w_bypass    = r_busy & w_empty & w_resp_ok & (r_ia == r_ba);

  assign w_pop      = w_hit | w_busy_head;
  assign w_push     = w_resp_ok & ~w_bypass & ~w_miss;
  assign w_deliver  = w_pop | w_bypass;
  assign w_out_data = w_bypass ? i_mem_rd_data : w_head;

  // count + infl never exceeds DEPTH, so a word issued now always has a slot.
  assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_infl};
  assign w_issue = ~i_reset & ~w_miss & (w_occ < C_DEPTH);

  assign o_mem_rd_req  = w_issue;
  assign o_mem_rd_addr = i_reset ? 16'h0000 : r_fa;
  assign o_ins_rd_rdy  = r_rdy;
  assign o_ins_rd_data = r_data;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_buf[w_wr_ptr] <= i_mem_rd_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ha      <= RESET_ADDR;
      r_fa      <= RESET_ADDR;
      r_infl    <= 1'b0;
      r_ia      <= 16'h0000;
      r_discard <= 1'b0;
      r_busy    <= 1'b0;
      r_ba      <= 16'h0000;
      r_rdy     <= 1'b0;
      r_data    <= 16'h0000;
    end else begin
      if (w_miss) begin
        r_count <= '0;
      end else if (w_push && !w_pop) begin
        r_count <= r_count + C_ONE;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - C_ONE;
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + P_ONE;
      end

      if (w_miss) begin
        r_ha <= i_ins_rd_addr;
      end else if (w_deliver) begin
        r_ha <= r_ha + 16'd1;
      end

      // A drop rewinds the issue pointer to the lost word; the request
      // issued alongside it is out of order and gets discarded.
      if (w_miss) begin
        r_fa <= i_ins_rd_addr;
      end else if (w_drop) begin
        r_fa <= r_ia;
      end else if (w_issue) begin
        r_fa <= r_fa + 16'd1;
      end

      r_infl    <= w_issue;
      r_discard <= w_issue & w_drop;
      if (w_issue) begin
        r_ia <= r_fa;
      end

      if (w_pend || w_miss) begin
        r_busy <= 1'b1;
        r_ba   <= i_ins_rd_addr;
      end else if (w_busy_head || w_bypass) begin
        r_busy <= 1'b0;
      end

      r_rdy <= w_deliver;
      if (w_deliver) begin
        r_data <= w_out_data;
      end
    end
  end

endmodule
